// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared bus widths, byte-select and size encodings, FSM states
package dmem_access_ctrl_pkg;
    localparam int WORD_BUS = 32;
    localparam int BSEL_BUS = 4;
    localparam logic [BSEL_BUS-1:0] BSEL_WORD = 4'b1111;
    localparam logic [BSEL_BUS-1:0] BSEL_HI   = 4'b1100;
    localparam logic [BSEL_BUS-1:0] BSEL_LO   = 4'b0011;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;
endpackage

// File: rtl/dmem_size_enc.sv
// dmem_size_enc: maps byte enables to the bus transfer size
module dmem_size_enc
    import dmem_access_ctrl_pkg::*;
(
    input  logic [BSEL_BUS-1:0] bsel,
    output logic [1:0]          size
);
    logic one_hot;
    always_comb begin
        one_hot = bsel != '0 && (bsel & (bsel - 4'd1)) == '0;
        size = bsel == BSEL_WORD ? SIZE_WORD :
               (bsel == BSEL_HI || bsel == BSEL_LO) ? SIZE_HALF :
               one_hot ? SIZE_BYTE : SIZE_WORD;
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one load/store per instruction over the SRAM-like data bus
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
(
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst_n,
    input  logic                mem_req_i,
    input  logic                mem_wr_i,
    input  logic [BSEL_BUS-1:0] mem_bsel_i,
    input  logic [WORD_BUS-1:0] mem_addr_i,
    input  logic [WORD_BUS-1:0] mem_wdata_i,
    input  logic                flush_i,
    input  logic                stall_i,
    output logic                data_req_o,
    output logic                data_wr_o,
    output logic [1:0]          data_size_o,
    output logic [WORD_BUS-1:0] data_addr_o,
    output logic [BSEL_BUS-1:0] data_wstrb_o,
    output logic [WORD_BUS-1:0] data_wdata_o,
    input  logic                data_addr_ok_i,
    input  logic                data_data_ok_i,
    input  logic [WORD_BUS-1:0] data_rdata_i,
    output logic [WORD_BUS-1:0] dm_o,
    output logic                mem_operation_ok_o,
    output logic                stall_req_o
);
    state_t state, state_nx;
    logic [WORD_BUS-1:0] dm;
    logic [1:0] size;
    logic issue, latch;

    dmem_size_enc u_size (.bsel(mem_bsel_i), .size(size));

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state <= S_IDLE;
            dm <= '0;
        end else begin
            state <= state_nx;
            if (latch) dm <= mem_wr_i ? '0 : data_rdata_i;
        end
    end

    // Once addr_ok has been seen the response must be drained, even under flush.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (mem_req_i && !flush_i) state_nx = data_addr_ok_i ? S_WAIT : S_REQ;
            S_REQ:   if (flush_i) state_nx = data_addr_ok_i ? S_DRAIN : S_IDLE;
                     else if (data_addr_ok_i) state_nx = S_WAIT;
            S_WAIT:  if (flush_i) state_nx = data_data_ok_i ? S_IDLE : S_DRAIN;
                     else if (data_data_ok_i) state_nx = S_DONE;
            S_DONE:  if (!stall_i || flush_i) state_nx = S_IDLE;
            S_DRAIN: if (data_data_ok_i) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Every output is forced low while reset is held, whatever the state register says.
    always_comb begin
        issue = state == S_IDLE && mem_req_i && !flush_i;
        latch = state == S_WAIT && data_data_ok_i && !flush_i;
        data_req_o = cpu_rst_n && (issue || (state == S_REQ && (!flush_i || data_addr_ok_i)));
        data_wr_o = cpu_rst_n && mem_wr_i;
        data_size_o = cpu_rst_n ? size : '0;
        data_addr_o = cpu_rst_n ? mem_addr_i : '0;
        data_wstrb_o = (cpu_rst_n && mem_wr_i) ? mem_bsel_i : '0;
        data_wdata_o = cpu_rst_n ? mem_wdata_i : '0;
        dm_o = cpu_rst_n ? dm : '0;
        mem_operation_ok_o = cpu_rst_n && (state == S_DONE || (state == S_IDLE && !mem_req_i));
        stall_req_o = cpu_rst_n && (issue || state == S_REQ || state == S_WAIT || state == S_DRAIN);
    end
endmodule
